// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Two-port arbiter and APB master sequencer for the 64x16 execute-stage-2
//   data memory. Port 0 is the pipeline load/store path. Port 1 is the
//   secondary master (program loader/debug). One transfer is outstanding at
//   a time.
//
//   Optional build macro: DATA_MEM_ARB_RR_EN selects round-robin arbitration
//   between the ports. When it is undefined, port 0 has fixed priority.
//
// Ports
//   clk, rst                  rising-edge clock, async active-low reset
//   pN_req/write/addr/wdata   port N request; req is held until pN_gnt
//   pN_gnt/done/err           registered one-cycle pulses back to port N
//   rdata                     last captured read data
//   busy                      transfer in flight (state != IDLE)
//   paddr/pwrite/psel/penable/pwdata/prdata/pready   APB master side
module data_mem_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic              p0_err,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic              p1_err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       win;      // arbitration result this cycle: 0 = port 0, 1 = port 1
  logic       win_id;   // port that owns the transfer in flight
  logic       any_req;
  logic       xfer_end; // last ACCESS cycle, by pready or by timeout
  logic       to_hit;

  assign any_req  = p0_req | p1_req;
  assign to_hit   = (state == ACCESS) && !pready && (cnt == TO);
  assign xfer_end = (state == ACCESS) && (pready || to_hit);
  assign busy     = (state != IDLE);

`ifdef DATA_MEM_ARB_RR_EN
  // rr_ptr names the port favoured on the next tie. After each grant it
  // points at the port that lost, so the last-granted port yields on a tie.
  // The reset value of 0 makes the first tie after reset go to port 0.
  logic rr_ptr;

  assign win = (p0_req && p1_req) ? rr_ptr : !p0_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          rr_ptr <= 1'b0;
    else if (state == IDLE && any_req) rr_ptr <= !win;
  end
`else
  assign win = !p0_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    psel      = 1'b0;
    penable   = 1'b0;
    case (state)
      IDLE:   if (any_req) state_nxt = SETUP;
      SETUP:  begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (xfer_end) state_nxt = DONE;
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered handshake pulses. The APB address, direction
  // and write data only load on a grant, so they hold through SETUP and
  // ACCESS and keep their last values while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      paddr   <= '0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      rdata   <= '0;
      cnt     <= '0;
      win_id  <= 1'b0;
      p0_gnt  <= 1'b0;
      p1_gnt  <= 1'b0;
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      p0_err  <= 1'b0;
      p1_err  <= 1'b0;
    end else begin
      p0_gnt  <= 1'b0;
      p1_gnt  <= 1'b0;
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      p0_err  <= 1'b0;
      p1_err  <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          paddr  <= win ? p1_addr  : p0_addr;
          pwrite <= win ? p1_write : p0_write;
          pwdata <= win ? p1_wdata : p0_wdata;
          win_id <= win;
          p0_gnt <= !win;
          p1_gnt <= win;
        end
        ACCESS: begin
          if (pready && !pwrite) rdata <= prdata;
          // The counter stops at TIMEOUT, so it never wraps.
          if (!pready && !to_hit) cnt <= cnt + 8'd1;
          if (xfer_end) begin
            p0_done <= !win_id;
            p1_done <= win_id;
            p0_err  <= to_hit && !win_id;
            p1_err  <= to_hit && win_id;
          end
        end
        DONE: cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule
